// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register-bank scheduler.
package reg_bank_pkg;
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned ADDR_W_DEF     = 4;
    localparam int unsigned NREG           = 16;
    localparam int unsigned STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_DBG_RD = 2'd2
    } state_e;
endpackage

// File: rtl/reg_bank_clr_seq.sv
// Clear address sequencer: walks register addresses while active and
// pulses done the cycle after the last address is driven.
module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              active_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              last_o,
    output logic              done_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              last;

    always_comb begin
        last   = active_i && (cnt_q == LAST_ADDR);
        cnt_d  = cnt_q;
        done_d = last;
        if (active_i) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign addr_o      = cnt_q;
    assign next_addr_o = cnt_q + 1'b1;
    assign last_o      = last;
    assign done_o      = done_q;
endmodule

// File: rtl/reg_bank_sched.sv
// Register-bank port scheduler: arbitrates clear, core writeback and debug
// access onto one registered write port and one registered read address.
module reg_bank_sched
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_req_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              wb_ready_o,
    input  logic              dbg_valid_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ready_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              clr_done_o
);
    localparam int unsigned   SW  = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              clr_g, wb_g, dbg_g, dbg_force;
    logic              clr_active, clr_last, clr_done;
    logic [ADDR_W-1:0] clr_addr, clr_next;

    assign clr_active = (state_q == ST_CLEAR);

    reg_bank_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .active_i    (clr_active),
        .addr_o      (clr_addr),
        .next_addr_o (clr_next),
        .last_o      (clr_last),
        .done_o      (clr_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_g) begin
                    state_d = ST_CLEAR;
                end else if (dbg_g && !dbg_we_i) begin
                    state_d = ST_DBG_RD;
                end
            end
            ST_CLEAR:  if (clr_last) state_d = ST_IDLE;
            ST_DBG_RD: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A saturated starvation counter lets a waiting debug request jump ahead of writeback.
    always_comb begin
        clr_g     = 1'b0;
        wb_g      = 1'b0;
        dbg_g     = 1'b0;
        dbg_force = (starve_q == LIM) && dbg_valid_i;
        if (state_q == ST_IDLE) begin
            clr_g = clr_req_i;
            wb_g  = !clr_req_i && wb_valid_i && !dbg_force;
            dbg_g = !clr_req_i && dbg_valid_i && (dbg_force || !wb_valid_i);
        end

        starve_d = starve_q;
        if (dbg_g) begin
            starve_d = '0;
        end else if ((state_q == ST_IDLE) && dbg_valid_i && (starve_q != LIM)) begin
            starve_d = starve_q + 1'b1;
        end

        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clr_g) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = '0;
        end else if (wb_g) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wb_addr_i;
            wr_data_d = wb_data_i;
        end else if (dbg_g && dbg_we_i) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dbg_addr_i;
            wr_data_d = dbg_wdata_i;
        end else if (clr_active && !clr_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_next;
            wr_data_d = '0;
        end

        rd_addr_d = (dbg_g && !dbg_we_i) ? dbg_addr_i : rd_addr_q;
        rvalid_d  = (state_q == ST_DBG_RD);
        rdata_d   = (state_q == ST_DBG_RD) ? rd_data_i : rdata_q;

        wb_ready_o  = wb_g;
        dbg_ready_o = dbg_g;
        busy_o      = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign rd_addr_o    = rd_addr_q;
    assign dbg_rvalid_o = rvalid_q;
    assign dbg_rdata_o  = rdata_q;
    assign clr_done_o   = clr_done;

    logic unused_clr_addr;
    assign unused_clr_addr = ^clr_addr;
endmodule

// File: tb/tb_reg_bank_sched.sv
// Directed bench for reg_bank_sched with a behavioural register-bank model.
module tb_reg_bank_sched;
    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic        dbg_valid;
    logic        dbg_we;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ready;
    logic        dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        clr_done;

    logic        preload;
    logic [15:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    reg_bank_sched #(
        .DATA_W     (16),
        .ADDR_W     (4),
        .STARVE_LIM (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_req_i    (clr_req),
        .wb_valid_i   (wb_valid),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .wb_ready_o   (wb_ready),
        .dbg_valid_i  (dbg_valid),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_ready_o  (dbg_ready),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .clr_done_o   (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank: writes on the rising edge, read port captured on the falling edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h5A00 + 16'(i);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end
    always @(negedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_en"},    32'(wr_en),      0);
        check({tag, ".wr_addr"},  32'(wr_addr),    0);
        check({tag, ".wr_data"},  32'(wr_data),    0);
        check({tag, ".rd_addr"},  32'(rd_addr),    0);
        check({tag, ".rvalid"},   32'(dbg_rvalid), 0);
        check({tag, ".rdata"},    32'(dbg_rdata),  0);
        check({tag, ".clr_done"}, 32'(clr_done),   0);
        check({tag, ".busy"},     32'(busy),       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr_req = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; preload = 1'b1;
        step(); step();
        preload = 1'b0;
        #1;
        check_all_zero("reset");
        check("reset.wb_ready", 32'(wb_ready), 0);

        // Release reset and request a writeback in the same cycle
        rst_n = 1'b1; wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        #1;
        check("wb.ready", 32'(wb_ready), 1);
        check("wb.dbg_ready", 32'(dbg_ready), 0);
        step();
        wb_valid = 1'b0; #1;
        check("wb.wr_en", 32'(wr_en), 1);
        check("wb.wr_addr", 32'(wr_addr), 3);
        check("wb.wr_data", 32'(wr_data), 'h1234);
        step(); #1;
        check("wb.wr_en_drop", 32'(wr_en), 0);

        // Debug read of register 3, writeback blocked while in DBG_RD
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd3; #1;
        check("rd3.ready", 32'(dbg_ready), 1);
        step();
        dbg_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF; #1;
        check("rd3.busy", 32'(busy), 1);
        check("rd3.rd_addr", 32'(rd_addr), 3);
        check("rd3.rvalid_early", 32'(dbg_rvalid), 0);
        check("rd3.wb_blocked", 32'(wb_ready), 0);
        step();
        wb_valid = 1'b0; #1;
        check("rd3.rvalid", 32'(dbg_rvalid), 1);
        check("rd3.rdata", 32'(dbg_rdata), 'h1234);
        check("rd3.idle", 32'(busy), 0);
        step(); #1;
        check("rd3.rvalid_pulse", 32'(dbg_rvalid), 0);
        check("rd3.rdata_hold", 32'(dbg_rdata), 'h1234);
        check("rd3.rd_addr_hold", 32'(rd_addr), 3);

        // Write then read-after-write on register 7
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF; #1;
        check("raw.wb_ready", 32'(wb_ready), 1);
        step();
        wb_valid = 1'b0; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd7; #1;
        check("raw.dbg_ready", 32'(dbg_ready), 1);
        check("raw.wr_addr", 32'(wr_addr), 7);
        step();
        dbg_valid = 1'b0; #1;
        check("raw.rd_addr", 32'(rd_addr), 7);
        step(); #1;
        check("raw.rvalid", 32'(dbg_rvalid), 1);
        check("raw.rdata", 32'(dbg_rdata), 'hBEEF);
        step();

        // Debug write goes straight to the write port without DBG_RD
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'hC0DE; #1;
        check("dw.ready", 32'(dbg_ready), 1);
        step();
        dbg_valid = 1'b0; dbg_we = 1'b0; #1;
        check("dw.wr_en", 32'(wr_en), 1);
        check("dw.wr_addr", 32'(wr_addr), 9);
        check("dw.wr_data", 32'(wr_data), 'hC0DE);
        check("dw.busy", 32'(busy), 0);
        step();

        // Starvation: wb wins 4 cycles, debug forced on the 5th
        wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 16'h1111;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd5;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stv.wb_ready", 32'(wb_ready), 1);
            check("stv.dbg_ready", 32'(dbg_ready), 0);
            step();
        end
        #1;
        check("stv.forced_dbg", 32'(dbg_ready), 1);
        check("stv.forced_wb", 32'(wb_ready), 0);
        step(); #1;
        check("stv.rd_wb_ready", 32'(wb_ready), 0);
        check("stv.rd_wr_en", 32'(wr_en), 0);
        step(); #1;
        check("stv.rvalid", 32'(dbg_rvalid), 1);
        check("stv.rdata", 32'(dbg_rdata), 'h5A05);
        check("stv.cnt_reset_wb", 32'(wb_ready), 1);
        check("stv.cnt_reset_dbg", 32'(dbg_ready), 0);
        step();
        wb_valid = 1'b0; dbg_valid = 1'b0;
        step();

        // Clear wins over a simultaneous writeback; writeback served after done
        clr_req = 1'b1; wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 16'h2222; #1;
        check("clr.wb_ready_c0", 32'(wb_ready), 0);
        step();
        for (int i = 0; i < 16; i++) begin
            clr_req = (i == 2);
            #1;
            check("clr.busy", 32'(busy), 1);
            check("clr.wr_en", 32'(wr_en), 1);
            check("clr.wr_addr", 32'(wr_addr), i);
            check("clr.wr_data", 32'(wr_data), 0);
            check("clr.wb_ready", 32'(wb_ready), 0);
            check("clr.done_early", 32'(clr_done), 0);
            step();
        end
        clr_req = 1'b0; #1;
        check("clr.done", 32'(clr_done), 1);
        check("clr.busy_end", 32'(busy), 0);
        check("clr.wr_en_end", 32'(wr_en), 0);
        check("clr.wb_after", 32'(wb_ready), 1);
        step();
        wb_valid = 1'b0; #1;
        check("clr.wb_wr_en", 32'(wr_en), 1);
        check("clr.wb_wr_addr", 32'(wr_addr), 2);
        check("clr.wb_wr_data", 32'(wr_data), 'h2222);
        check("clr.done_pulse", 32'(clr_done), 0);
        check("clr.mem15", 32'(mem[15]), 0);
        check("clr.mem9", 32'(mem[9]), 0);
        step();

        // Reset during a clear aborts it
        preload = 1'b1;
        step();
        preload = 1'b0; clr_req = 1'b1; #1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("abort.wr_addr", 32'(wr_addr), i);
            step();
        end
        rst_n = 1'b0; #1;
        check_all_zero("abort");
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("abort.no_done", 32'(clr_done), 0);
            check("abort.no_wr", 32'(wr_en), 0);
            check("abort.no_busy", 32'(busy), 0);
            step();
        end
        check("abort.mem5", 32'(mem[5]), 0);
        check("abort.mem6", 32'(mem[6]), 'h5A06);
        check("abort.mem15", 32'(mem[15]), 'h5A0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_bank_sched.md
REG_BANK_SCHED -- requirements
Module: reg_bank_sched

Interface
REQ-001 Parameter DATA_W, default 16, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 Parameter STARVE_LIM, default 4, consecutive denied debug cycles before debug is forced a grant.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clr_req  input  1  request to zero all registers.
REQ-007 wb_valid  input  1  core writeback request.
REQ-008 wb_addr  input  ADDR_W  writeback destination register.
REQ-009 wb_data  input  DATA_W  writeback data.
REQ-010 wb_ready  output  1  writeback accepted this cycle (combinational).
REQ-011 dbg_valid  input  1  debug request.
REQ-012 dbg_we  input  1  1 = debug write, 0 = debug read.
REQ-013 dbg_addr  input  ADDR_W  debug register address.
REQ-014 dbg_wdata  input  DATA_W  debug write data.
REQ-015 dbg_ready  output  1  debug request accepted this cycle (combinational).
REQ-016 dbg_rvalid  output  1  one-cycle pulse, dbg_rdata valid.
REQ-017 dbg_rdata  output  DATA_W  debug read data, held until next read completes.
REQ-018 rd_addr  output  ADDR_W  registered read address to bank port A.
REQ-019 rd_data  input  DATA_W  bank port A data (bank captures on falling edge).
REQ-020 wr_en, wr_addr, wr_data  output  1/ADDR_W/DATA_W  registered bank write port.
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 clr_done  output  1  one-cycle pulse when clear completes.

Function
REQ-023 FSM states IDLE, CLEAR, DBG_RD; exactly one grant (clear, wb or dbg) per cycle, and only in IDLE.
REQ-024 IDLE priority: clr_req > wb_valid > dbg_valid, except REQ-026.
REQ-025 starve_cnt increments each IDLE cycle with dbg_valid high and dbg not granted; saturates at STARVE_LIM; clears on any dbg grant.
REQ-026 When starve_cnt == STARVE_LIM and dbg_valid, dbg is granted over wb; clr_req still wins.
REQ-027 Granted write (wb or dbg write) accepted in cycle N appears as wr_en=1 with its addr/data in cycle N+1 only; wr_en=0 otherwise.
REQ-028 clr_req in IDLE: enter CLEAR next cycle; CLEAR drives wr_en=1, wr_data=0, wr_addr=0,1,...,15 on 16 consecutive cycles (all 16 registers).
REQ-029 On the cycle wr_addr=15 is driven, FSM returns to IDLE next cycle and clr_done pulses in that cycle.
REQ-030 wb_ready=dbg_ready=0 throughout CLEAR and DBG_RD; clr_req during CLEAR or DBG_RD is ignored (not queued).
REQ-031 Debug read accepted in cycle N: rd_addr=dbg_addr in N+1 (state DBG_RD); dbg_rdata loaded from rd_data at end of N+1; dbg_rvalid=1 in N+2; FSM in IDLE in N+2.
REQ-032 A write accepted in N-1 to the address read-accepted in N is committed before the read samples; dbg_rdata returns the new value.
REQ-033 rd_addr holds its last value outside DBG_RD.
REQ-034 Simultaneous wb_valid and dbg_valid with starve_cnt < STARVE_LIM: wb granted, dbg_ready=0.

Reset
REQ-035 reset low asynchronously forces: state IDLE, starve_cnt 0, clear counter 0, wr_en 0, wr_addr 0, wr_data 0, rd_addr 0, dbg_rvalid 0, dbg_rdata 0, clr_done 0, busy 0.
REQ-036 Reset asserted mid-CLEAR or mid-DBG_RD aborts the operation; no clr_done or dbg_rvalid after release; remaining registers are not zeroed.
REQ-037 First grant possible in the first rising edge after reset deasserts.

Structure
REQ-038 Shared package reg_bank_pkg holds the state enum, DATA_W/ADDR_W defaults, NREG=16 and STARVE_LIM default.
REQ-039 The 16-step clear address counter and done pulse form one sub-module, reg_bank_clr_seq; the arbiter FSM stays in reg_bank_sched.

Verification
REQ-040 wb_valid=1, wb_addr=3, wb_data=16'h1234 in IDLE -> wb_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=16'h1234.
REQ-041 clr_req pulse -> busy for 16 cycles, wr_addr 0..15 with wr_data 0, clr_done pulse after wr_addr=15; wb_valid held during clear sees wb_ready=0.
REQ-042 wb_valid and dbg_valid (read, addr 5) held high continuously -> wb granted 4 cycles, then dbg granted on the 5th; starve_cnt returns to 0.
REQ-043 wb write addr 7 = 16'hBEEF accepted in N, dbg read addr 7 accepted in N+1 -> dbg_rvalid in N+3 with dbg_rdata=16'hBEEF.
REQ-044 clr_req, then reset low after 6 clear cycles -> all outputs 0 immediately; after release no clr_done; registers 6..15 not written.
REQ-045 clr_req and wb_valid same IDLE cycle -> wb_ready=0, CLEAR entered, wb granted in first IDLE cycle after clr_done.
